// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write scheduler.
package regfile_pkg;

  localparam int unsigned REG_W    = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZR_IDX = 5'd31;

  // Arbiter priority state
  typedef enum logic {
    APrio = 1'b0,
    BPrio = 1'b1
  } arb_state_e;

  // One buffered register-file write
  typedef struct packed {
    logic [ADDR_W-1:0] rw;
    logic [REG_W-1:0]  data;
  } wr_entry_t;

  // One-hot register mask; XZR never shows as pending
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] idx,
                                                     input logic en);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (en && (idx != ZR_IDX)) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/reg_write_fifo.sv
// Source-B write buffer: small FIFO of {RW, Data} entries with wrap-bit pointers.
module reg_write_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  wr_entry_t           push_entry_i,
  input  logic                pop_i,
  output wr_entry_t           head_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [NUM_REGS-1:0] rw_mask_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] count;
  wr_entry_t       mem_q [DEPTH];

  assign count   = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = ((wptr_q ^ rptr_q) == {1'b1, {IdxW{1'b0}}});
  assign head_o  = mem_q[rptr_q[IdxW-1:0]];

  // Pointer advance; a full FIFO ignores push even when popping (no bypass)
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i && !full_o) wptr_d = wptr_q + 1'b1;
    if (pop_i && !empty_o) rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; contents are only meaningful between rptr and wptr
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wptr_q[IdxW-1:0]] <= push_entry_i;
  end

  // Destination mask of every occupied entry
  always_comb begin
    rw_mask_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rw_mask_o = rw_mask_o | reg_onehot(mem_q[IdxW'(rptr_q[IdxW-1:0] + IdxW'(k))].rw,
                                         (PtrW'(k) < count));
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between a 1-entry source-A holder and a
// FIFO-buffered source B, A-first with a starvation guard for B.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned B_DEPTH      = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                A_Valid,
  output logic                A_Ready,
  input  logic [ADDR_W-1:0]   A_RW,
  input  logic [REG_W-1:0]    A_Data,
  input  logic                B_Valid,
  output logic                B_Ready,
  input  logic [ADDR_W-1:0]   B_RW,
  input  logic [REG_W-1:0]    B_Data,
  output logic                RegWr,
  output logic [ADDR_W-1:0]   RW,
  output logic [REG_W-1:0]    BusW,
  output logic                WrSrc,
  output logic [NUM_REGS-1:0] Pending
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic       a_full_q, a_full_d;
  wr_entry_t  a_entry_q, a_entry_d;
  logic       a_grant, b_grant;
  logic       a_keep, b_push;

  wr_entry_t           b_head;
  logic                b_empty, b_full, b_valid;
  logic [NUM_REGS-1:0] b_mask;

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic              regwr_q, regwr_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [REG_W-1:0]  busw_q, busw_d;
  logic              wrsrc_q, wrsrc_d;

  assign b_valid = ~b_empty;
  assign A_Ready = ~a_full_q | a_grant;
  assign B_Ready = ~b_full;
  // XZR writes complete the handshake but are never stored
  assign a_keep  = A_Valid & A_Ready & (A_RW != ZR_IDX);
  assign b_push  = B_Valid & ~b_full & (B_RW != ZR_IDX);

  reg_write_fifo #(
    .DEPTH (B_DEPTH)
  ) u_b_fifo (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .push_i       (b_push),
    .push_entry_i ('{rw: B_RW, data: B_Data}),
    .pop_i        (b_grant),
    .head_o       (b_head),
    .empty_o      (b_empty),
    .full_o       (b_full),
    .rw_mask_o    (b_mask)
  );

  // Arbiter state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= APrio;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbiter next state: count A wins over a waiting B, hand B one slot at the limit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (a_full_q && b_valid && (state_q == APrio)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntW'(STARVE_LIMIT - 1)) state_d = BPrio;
    end else begin
      cnt_d   = '0;
      state_d = APrio;
    end
  end

  // Arbiter outputs: grant decision
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (a_full_q && b_valid) begin
      if (state_q == BPrio) b_grant = 1'b1;
      else                  a_grant = 1'b1;
    end else if (a_full_q) begin
      a_grant = 1'b1;
    end else if (b_valid) begin
      b_grant = 1'b1;
    end
  end

  // Source-A holder next state; push and pop may coincide
  always_comb begin
    a_full_d  = a_full_q;
    a_entry_d = a_entry_q;
    if (a_keep) begin
      a_full_d  = 1'b1;
      a_entry_d = '{rw: A_RW, data: A_Data};
    end else if (a_grant) begin
      a_full_d = 1'b0;
    end
  end

  // Output stage next state; address/data hold when idle
  always_comb begin
    regwr_d = 1'b0;
    rw_d    = rw_q;
    busw_d  = busw_q;
    wrsrc_d = wrsrc_q;
    if (a_grant) begin
      regwr_d = 1'b1;
      rw_d    = a_entry_q.rw;
      busw_d  = a_entry_q.data;
      wrsrc_d = 1'b0;
    end else if (b_grant) begin
      regwr_d = 1'b1;
      rw_d    = b_head.rw;
      busw_d  = b_head.data;
      wrsrc_d = 1'b1;
    end
  end

  // Holder and output-stage registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_full_q  <= 1'b0;
      a_entry_q <= '0;
      regwr_q   <= 1'b0;
      rw_q      <= '0;
      busw_q    <= '0;
      wrsrc_q   <= 1'b0;
    end else begin
      a_full_q  <= a_full_d;
      a_entry_q <= a_entry_d;
      regwr_q   <= regwr_d;
      rw_q      <= rw_d;
      busw_q    <= busw_d;
      wrsrc_q   <= wrsrc_d;
    end
  end

  // Pending mask over every in-flight write
  always_comb begin
    Pending = reg_onehot(a_entry_q.rw, a_full_q) | b_mask | reg_onehot(rw_q, regwr_q);
  end

  assign RegWr = regwr_q;
  assign RW    = rw_q;
  assign BusW  = busw_q;
  assign WrSrc = wrsrc_q;

endmodule
